times_table_axil_slave: RTL and testbench

// AXI4-lite responder that serves a 0..7 x 0..7 times table to an AXI4-lite initiator.

---
 rtl/times_table_axil_slave.sv | 135 +++++++++++++
 tb/tb_times_table_axil_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/times_table_axil_slave.sv
// times_table_axil_slave: AXI4-lite responder holding a writable 8x8 byte times table.
// Reads sample the table READ_WAIT+1 cycles after AR acceptance; writes commit once AW and W are both held.
module times_table_axil_slave #(
  parameter int READ_WAIT = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  r_state_t r_rstate, w_rnext;
  w_state_t r_wstate, w_wnext;
  logic [7:0] r_mem [64];
  logic [7:0] r_rdata, r_wdata, w_wbyte;
  logic [5:0] r_ar_idx, r_aw_idx, w_widx;
  logic [3:0] r_cnt;
  logic [1:0] r_rresp, r_bresp;
  logic r_ar_oor, r_aw_oor, r_aw_held, r_w_held, r_wstrb0;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_sample, w_commit, w_woor, w_wstrb0;
  logic w_unused;
  assign w_unused = ^{s_axi_araddr[1:0], s_axi_awaddr[1:0], s_axi_wdata[DATA_W-1:8], s_axi_wstrb[3:1]};
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs = s_axi_wvalid & s_axi_wready;
  assign w_sample = (r_rstate == R_WAIT) && (r_cnt == 4'(READ_WAIT));
  assign w_commit = (r_wstate == W_IDLE) && (r_aw_held | w_aw_hs) && (r_w_held | w_w_hs);
  // Either half of the write may arrive on the commit cycle itself, so take it straight from the bus.
  assign w_widx = r_aw_held ? r_aw_idx : s_axi_awaddr[7:2];
  assign w_woor = r_aw_held ? r_aw_oor : |s_axi_awaddr[ADDR_W-1:8];
  assign w_wbyte = r_w_held ? r_wdata : s_axi_wdata[7:0];
  assign w_wstrb0 = r_w_held ? r_wstrb0 : s_axi_wstrb[0];
  assign s_axi_rdata = {{(DATA_W-8){1'b0}}, r_rdata};
  assign s_axi_rresp = r_rresp;
  assign s_axi_bresp = r_bresp;

  always_ff @(posedge clk) r_rstate <= rst ? R_IDLE : w_rnext;

  always_comb
    w_rnext = r_rstate == R_IDLE ? (s_axi_arvalid ? R_WAIT : R_IDLE)
            : r_rstate == R_WAIT ? (w_sample ? R_DATA : R_WAIT)
            : (s_axi_rready ? R_IDLE : R_DATA);

  always_comb begin
    s_axi_arready = r_rstate == R_IDLE;
    s_axi_rvalid = r_rstate == R_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ar_idx <= '0;
      r_ar_oor <= 1'b0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else begin
      if (w_ar_hs) begin
        r_ar_idx <= s_axi_araddr[7:2];
        r_ar_oor <= |s_axi_araddr[ADDR_W-1:8];
        r_cnt <= '0;
      end else if (r_rstate == R_WAIT && !w_sample) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_sample) begin
        r_rdata <= r_ar_oor ? 8'd0 : r_mem[r_ar_idx];
        r_rresp <= r_ar_oor ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge clk) r_wstate <= rst ? W_IDLE : w_wnext;

  always_comb
    w_wnext = r_wstate == W_IDLE ? (w_commit ? W_RESP : W_IDLE) : (s_axi_bready ? W_IDLE : W_RESP);

  always_comb begin
    s_axi_awready = (r_wstate == W_IDLE) && !r_aw_held;
    s_axi_wready = (r_wstate == W_IDLE) && !r_w_held;
    s_axi_bvalid = r_wstate == W_RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held <= 1'b0;
      r_aw_idx <= '0;
      r_aw_oor <= 1'b0;
      r_wdata <= '0;
      r_wstrb0 <= 1'b0;
      r_bresp <= 2'b00;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held <= 1'b0;
      r_bresp <= w_woor ? 2'b10 : 2'b00;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx <= s_axi_awaddr[7:2];
        r_aw_oor <= |s_axi_awaddr[ADDR_W-1:8];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata <= s_axi_wdata[7:0];
        r_wstrb0 <= s_axi_wstrb[0];
      end
    end
  end

  // Nonblocking update keeps a same-cycle read sample on the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) r_mem[i] <= {5'd0, i[5:3]} * {5'd0, i[2:0]};
    end else if (w_commit && w_wstrb0 && !w_woor) begin
      r_mem[w_widx] <= w_wbyte;
    end
  end
endmodule

// File: tb/tb_times_table_axil_slave.sv
// tb_times_table_axil_slave: vector table, reset/hold corner sequences and random traffic
// checked against an array model of the times table.
module tb_times_table_axil_slave;
  localparam int RW = 1;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0] s_axi_wstrb;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  int checks = 0, errors = 0;
  logic [7:0] model [64];

  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] strb;
    int lead;
    logic [1:0] resp;
    logic [7:0] data;
  } vec_t;
  vec_t vecs [14];

  always #5 clk = ~clk;

  times_table_axil_slave #(.READ_WAIT(RW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) model[i] = 8'((i / 8) * (i % 8));
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr[31:8] != 0) return 2'b10;
    if (strb[0]) model[addr[7:2]] = data[7:0];
    return 2'b00;
  endfunction

  function automatic logic [9:0] model_read(input logic [31:0] addr);
    return addr[31:8] != 0 ? 10'h200 : {2'b00, model[addr[7:2]]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, output logic [7:0] d, output logic [1:0] resp);
    int n, lat;
    logic [31:0] held;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    s_axi_arvalid = 1'b1;
    s_axi_araddr = addr;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    lat = 0;
    while (!s_axi_rvalid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rd_latency", lat, RW + 1);
    d = s_axi_rdata[7:0];
    resp = s_axi_rresp;
    held = s_axi_rdata;
    for (int k = 0; k < hold; k++) begin
      s_axi_arvalid = 1'b1;
      s_axi_araddr = 32'h0;
      @(posedge clk); #1;
      chk("rd_hold_valid", s_axi_rvalid, 1);
      chk("rd_hold_data", s_axi_rdata, held);
      chk("rd_hold_arready", s_axi_arready, 0);
    end
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    chk("rd_rvalid_drop", s_axi_rvalid, 0);
    chk("rd_arready_back", s_axi_arready, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int hold, output logic [1:0] resp);
    int n;
    bit a_done, w_done, a_hs, w_hs;
    n = 0;
    a_done = 0;
    w_done = 0;
    s_axi_awaddr = addr;
    s_axi_wdata = data;
    s_axi_wstrb = strb;
    while (!(a_done && w_done) && n < 40) begin
      if (!a_done && n >= (lead < 0 ? -lead : 0)) s_axi_awvalid = 1'b1;
      if (!w_done && n >= (lead > 0 ? lead : 0)) s_axi_wvalid = 1'b1;
      a_hs = s_axi_awvalid & s_axi_awready;
      w_hs = s_axi_wvalid & s_axi_wready;
      @(posedge clk); #1;
      if (a_hs) begin a_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; s_axi_wvalid = 1'b0; end
      if (a_done && !w_done) chk("wr_awready_held", s_axi_awready, 0);
      if (w_done && !a_done) chk("wr_wready_held", s_axi_wready, 0);
      n++;
    end
    chk("wr_handshake_bound", {31'd0, n < 40}, 1);
    chk("wr_bvalid", s_axi_bvalid, 1);
    resp = s_axi_bresp;
    for (int k = 0; k < hold; k++) begin
      s_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      chk("wr_hold_bvalid", s_axi_bvalid, 1);
      chk("wr_hold_bresp", s_axi_bresp, resp);
      chk("wr_hold_awready", s_axi_awready, 0);
    end
    s_axi_awvalid = 1'b0;
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    chk("wr_bvalid_drop", s_axi_bvalid, 0);
    chk("wr_awready_back", s_axi_awready, 1);
    chk("wr_wready_back", s_axi_wready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] resp;
    logic [9:0] exp;
    logic [31:0] addr, data;
    int hold, lead;
    vecs[0]  = '{0, 32'h0000_00D4, 32'h0, 4'h0, 0, 2'b00, 8'd30};
    vecs[1]  = '{1, 32'h0000_001C, 32'hAB, 4'h1, 1, 2'b00, 8'h00};
    vecs[2]  = '{0, 32'h0000_001C, 32'h0, 4'h0, 0, 2'b00, 8'hAB};
    vecs[3]  = '{1, 32'h0000_001C, 32'h55, 4'h0, 0, 2'b00, 8'h00};
    vecs[4]  = '{0, 32'h0000_001C, 32'h0, 4'h0, 0, 2'b00, 8'hAB};
    vecs[5]  = '{0, 32'h0000_0100, 32'h0, 4'h0, 0, 2'b10, 8'h00};
    vecs[6]  = '{1, 32'h0000_0100, 32'h11, 4'h1, -1, 2'b10, 8'h00};
    vecs[7]  = '{0, 32'h0000_0000, 32'h0, 4'h0, 0, 2'b00, 8'h00};
    vecs[8]  = '{0, 32'h0000_00FC, 32'h0, 4'h0, 0, 2'b00, 8'd49};
    vecs[9]  = '{0, 32'h0000_002B, 32'h0, 4'h0, 0, 2'b00, 8'd2};
    vecs[10] = '{1, 32'h0000_0024, 32'h177, 4'hF, -2, 2'b00, 8'h00};
    vecs[11] = '{0, 32'h0000_0027, 32'h0, 4'h0, 0, 2'b00, 8'h77};
    vecs[12] = '{0, 32'h8000_0024, 32'h0, 4'h0, 0, 2'b10, 8'h00};
    vecs[13] = '{0, 32'h0000_00B8, 32'h0, 4'h0, 0, 2'b00, 8'd30};
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    do_reset();
    chk("rst_arready", s_axi_arready, 1);
    chk("rst_awready", s_axi_awready, 1);
    chk("rst_wready", s_axi_wready, 1);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    for (int i = 0; i < 64; i++) begin
      do_read({24'd0, 6'(i), 2'b00}, 0, d, resp);
      chk("sweep_data", d, (i / 8) * (i % 8));
      chk("sweep_resp", resp, 0);
    end
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].wr) begin
        do_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].lead, 0, resp);
        void'(model_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb));
        chk("vec_bresp", resp, vecs[v].resp);
      end else begin
        do_read(vecs[v].addr, 0, d, resp);
        chk("vec_rdata", d, vecs[v].data);
        chk("vec_rresp", resp, vecs[v].resp);
      end
    end
    do_read(32'h0000_00D4, 5, d, resp);
    chk("hold_rdata", d, 30);
    do_write(32'h0000_0030, 32'h3C, 4'h1, 0, 5, resp);
    void'(model_write(32'h0000_0030, 32'h3C, 4'h1));
    chk("hold_bresp", resp, 0);
    do_read(32'h0000_0030, 0, d, resp);
    chk("hold_write_readback", d, 8'h3C);
    for (int t = 0; t < 150; t++) begin
      addr = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) addr[31:8] = 24'($urandom_range(1, 24'hFF_FFFF));
      hold = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        lead = int'($urandom_range(0, 4)) - 2;
        do_write(addr, data, 4'($urandom), lead, hold, resp);
        chk("rnd_bresp", resp, model_write(addr, data, s_axi_wstrb));
      end else begin
        do_read(addr, hold, d, resp);
        exp = model_read(addr);
        chk("rnd_rdata", d, exp[7:0]);
        chk("rnd_rresp", resp, exp[9:8]);
      end
    end
    do_write(32'h0000_0024, 32'h5A, 4'h1, 0, 0, resp);
    do_read(32'h0000_0024, 0, d, resp);
    chk("pre_rst_entry9", d, 8'h5A);
    s_axi_arvalid = 1'b1;
    s_axi_araddr = 32'h0000_0024;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    chk("mid_wait_arready", s_axi_arready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_arready", s_axi_arready, 1);
    for (int k = 0; k < 4; k++) begin
      chk("abort_rvalid", s_axi_rvalid, 0);
      @(posedge clk); #1;
    end
    do_read(32'h0000_0024, 0, d, resp);
    chk("abort_entry9", d, 1);
    chk("abort_entry9_resp", resp, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
